// File: rtl/lifo_fifo_buffer_if.sv
// Producer/consumer bundle for lifo_fifo_buffer: the master drives requests,
// the slave (the buffer) returns head data, occupancy flags and errors.
interface lifo_fifo_buffer_if #(
    parameter int data_width = 8,
    parameter int addr_width = 4
);
    logic                  mode;
    logic                  push;
    logic                  pop;
    logic [data_width-1:0] w_data;
    logic                  clr_err;
    logic [data_width-1:0] r_data;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [addr_width:0]   count;
    logic                  active_mode;
    logic                  err_overflow;
    logic                  err_underflow;

    modport master (
        output mode, push, pop, w_data, clr_err,
        input  r_data, empty, full, almost_empty, almost_full, count,
               active_mode, err_overflow, err_underflow
    );

    modport slave (
        input  mode, push, pop, w_data, clr_err,
        output r_data, empty, full, almost_empty, almost_full, count,
               active_mode, err_overflow, err_underflow
    );
endinterface

// File: rtl/lifo_fifo_buffer.sv
// Dual-policy storage buffer: stack (LIFO) or queue (FIFO), policy latched
// only while empty; show-ahead head data, occupancy flags, sticky errors.
module lifo_fifo_buffer #(
    parameter int data_width = 8,
    parameter int addr_width = 4,
    parameter int af_level   = 2**addr_width - 2,
    parameter int ae_level   = 2
) (
    input logic               clk,
    input logic               reset,
    lifo_fifo_buffer_if.slave bus
);
    localparam int DEPTH = 2**addr_width;
    localparam logic [addr_width:0]   FULL_CNT = {1'b1, {addr_width{1'b0}}};
    localparam logic [addr_width:0]   CNT_ONE  = (addr_width+1)'(1);
    localparam logic [addr_width-1:0] PTR_ONE  = addr_width'(1);

    typedef enum logic {MODE_LIFO = 1'b0, MODE_FIFO = 1'b1} mode_e;

    logic [data_width-1:0] mem_q [DEPTH];
    logic [addr_width:0]   count_q, count_d;
    logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
    mode_e                 mode_q, mode_d, eff_mode;
    logic                  err_ov_q, err_ov_d;
    logic                  err_un_q, err_un_d;

    logic                  is_empty, is_full, pop_ok, push_ok, we;
    logic [addr_width-1:0] waddr, top_idx;
    logic [addr_width:0]   cnt_m1;

    always_comb begin
        is_empty = (count_q == '0);
        is_full  = (count_q == FULL_CNT);
        pop_ok   = bus.pop & ~is_empty;
        push_ok  = bus.push & (~is_full | pop_ok);
        // An empty buffer takes the incoming policy this edge, so a push
        // accepted now is placed where the new policy will look for it.
        eff_mode = is_empty ? mode_e'(bus.mode) : mode_q;
        cnt_m1   = count_q - CNT_ONE;
        top_idx  = cnt_m1[addr_width-1:0];
    end

    always_comb begin
        mode_d   = eff_mode;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        we       = push_ok;
        waddr    = '0;

        if (push_ok & ~pop_ok)
            count_d = count_q + CNT_ONE;
        else if (pop_ok & ~push_ok)
            count_d = cnt_m1;

        if (eff_mode == MODE_LIFO) begin
            waddr = pop_ok ? top_idx : count_q[addr_width-1:0];
        end else begin
            waddr = wr_ptr_q;
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (is_empty & ~push_ok) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end

        err_ov_d = bus.clr_err ? 1'b0 : err_ov_q;
        if (bus.push & ~push_ok) err_ov_d = 1'b1;
        err_un_d = bus.clr_err ? 1'b0 : err_un_q;
        if (bus.pop & is_empty) err_un_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mode_q   <= MODE_LIFO;
            err_ov_q <= 1'b0;
            err_un_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mode_q   <= mode_d;
            err_ov_q <= err_ov_d;
            err_un_q <= err_un_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we & ~reset)
            mem_q[waddr] <= bus.w_data;
    end

    always_comb begin
        bus.r_data = '0;
        if (!is_empty)
            bus.r_data = (mode_q == MODE_LIFO) ? mem_q[top_idx] : mem_q[rd_ptr_q];
        bus.empty         = is_empty;
        bus.full          = is_full;
        bus.almost_empty  = (int'(count_q) <= ae_level);
        bus.almost_full   = (int'(count_q) >= af_level);
        bus.count         = count_q;
        bus.active_mode   = mode_q;
        bus.err_overflow  = err_ov_q;
        bus.err_underflow = err_un_q;
    end
endmodule

// File: tb/tb_lifo_fifo_buffer.sv
// Scoreboard bench for lifo_fifo_buffer: a queue-based reference model
// predicts the post-edge outputs; a monitor compares after every edge.
module tb_lifo_fifo_buffer;
    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AE    = 2;
    localparam int AF    = DEPTH - 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lifo_fifo_buffer_if #(.data_width(DW), .addr_width(AW)) bus ();

    lifo_fifo_buffer #(.data_width(DW), .addr_width(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [DW-1:0] r;
        logic [AW:0]   cnt;
        logic          e, f, ae, af, am, eo, eu;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [DW-1:0] mq[$];
    logic          m_mode, m_eo, m_eu;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int n = mq.size();
        e.cnt = (AW+1)'(n);
        e.e   = (n == 0);
        e.f   = (n == DEPTH);
        e.ae  = (n <= AE);
        e.af  = (n >= AF);
        e.r   = (n == 0) ? '0 : (m_mode ? mq[0] : mq[n-1]);
        e.am  = m_mode;
        e.eo  = m_eo;
        e.eu  = m_eu;
        return e;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_mode = 1'b0;
        m_eo   = 1'b0;
        m_eu   = 1'b0;
    endtask

    // Drive one cycle's request and predict the state after the next edge.
    task automatic apply(input logic md, input logic ps, input logic pp,
                         input logic [DW-1:0] wd, input logic clr);
        bit emp, ful, pop_ok, push_ok;
        bus.mode = md; bus.push = ps; bus.pop = pp; bus.w_data = wd; bus.clr_err = clr;
        emp = (mq.size() == 0);
        ful = (mq.size() == DEPTH);
        if (emp) m_mode = md;
        pop_ok  = pp && !emp;
        push_ok = ps && (!ful || pop_ok);
        if (pop_ok) begin
            if (m_mode) void'(mq.pop_front());
            else        void'(mq.pop_back());
        end
        if (push_ok) mq.push_back(wd);
        if (clr) begin m_eo = 1'b0; m_eu = 1'b0; end
        if (ps && !push_ok) m_eo = 1'b1;
        if (pp && emp)      m_eu = 1'b1;
        exp_q.push_back(model_out());
    endtask

    task automatic cyc(input logic md, input logic ps, input logic pp,
                       input logic [DW-1:0] wd, input logic clr);
        @(negedge clk);
        apply(md, ps, pp, wd, clr);
    endtask

    task automatic async_reset_check();
        @(negedge clk);
        bus.push = 1'b1; bus.pop = 1'b0; bus.w_data = 8'h5A; bus.clr_err = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("async_rst_count", 32'(bus.count), 32'd0);
        check("async_rst_empty", 32'(bus.empty), 32'd1);
        check("async_rst_rdata", 32'(bus.r_data), 32'd0);
        #1 reset = 1'b0;
        model_reset();
        apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("r_data",        32'(bus.r_data),        32'(e.r));
                check("count",         32'(bus.count),         32'(e.cnt));
                check("empty",         32'(bus.empty),         32'(e.e));
                check("full",          32'(bus.full),          32'(e.f));
                check("almost_empty",  32'(bus.almost_empty),  32'(e.ae));
                check("almost_full",   32'(bus.almost_full),   32'(e.af));
                check("active_mode",   32'(bus.active_mode),   32'(e.am));
                check("err_overflow",  32'(bus.err_overflow),  32'(e.eo));
                check("err_underflow", 32'(bus.err_underflow), 32'(e.eu));
            end
        end
    end

    initial begin : driver
        logic md;
        bus.mode = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.w_data = '0; bus.clr_err = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_empty",        32'(bus.empty),         32'd1);
        check("rst_full",         32'(bus.full),          32'd0);
        check("rst_count",        32'(bus.count),         32'd0);
        check("rst_r_data",       32'(bus.r_data),        32'd0);
        check("rst_active_mode",  32'(bus.active_mode),   32'd0);
        check("rst_almost_empty", 32'(bus.almost_empty),  32'd1);
        check("rst_almost_full",  32'(bus.almost_full),   32'd0);
        check("rst_err_ov",       32'(bus.err_overflow),  32'd0);
        check("rst_err_un",       32'(bus.err_underflow), 32'd0);
        reset = 1'b0;
        apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // LIFO fill, overflow, drain
        for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h11 * i), 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 8'h55, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // FIFO with write-pointer wrap
        for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'hB1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'hB2, 1'b0);
        repeat (4) cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);

        // Simultaneous push+pop when full, LIFO then FIFO
        for (int m = 0; m < 2; m++) begin
            for (int i = 1; i <= 4; i++) cyc(1'(m), 1'b1, 1'b0, 8'(i), 1'b0);
            cyc(1'(m), 1'b1, 1'b1, 8'h99, 1'b0);
            repeat (4) cyc(1'(m), 1'b0, 1'b1, 8'h00, 1'b0);
        end

        // Push+pop on empty, then drain
        cyc(1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);

        // Mode change ignored while occupied, taken once empty
        cyc(1'b0, 1'b1, 1'b0, 8'h31, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 8'h32, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        // Error set/clear priority
        cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // Async reset with three words stored
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
        async_reset_check();

        // Randomised traffic
        md = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) md = ~md;
            cyc(md, ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
                8'($urandom_range(0, 255)), ($urandom_range(0, 19) == 0));
        end
        cyc(md, 1'b0, 1'b0, 8'h00, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
